aes_state_unloader: RTL and testbench



---
 rtl/aes_state_unloader.sv | 80 ++++++++
 tb/tb_aes_state_unloader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_state_unloader.sv
// AES state unloader: captures a finished 128-bit block, streams it as byte beats.
// Optional per-byte parity output enabled by defining AES_UNLOAD_PARITY_EN.
module aes_state_unloader #(
    parameter int N          = 16,
    parameter int BEAT_BYTES = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N-1:0][7:0]       in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BEAT_BYTES*8-1:0] out_data,
    output logic                    out_last,
`ifdef AES_UNLOAD_PARITY_EN
    output logic [BEAT_BYTES-1:0]   out_parity,
`endif
    output logic                    busy
);

    localparam int BEATS = N / BEAT_BYTES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [N-1:0][7:0]   buf_q;

    // Same bits regrouped so beat k is bytes k*BEAT_BYTES.. with byte 0 low.
    logic [BEATS-1:0][BEAT_BYTES*8-1:0] beats_w;
    assign beats_w = buf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        buf_q   <= in_data;
                        cnt_q   <= '0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (cnt_q == LAST) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == SEND);
    assign out_valid = (state_q == SEND);
    assign out_last  = (state_q == SEND) && (cnt_q == LAST);
    assign out_data  = beats_w[cnt_q];

`ifdef AES_UNLOAD_PARITY_EN
    for (genvar j = 0; j < BEAT_BYTES; j++) begin : g_par
        assign out_parity[j] = ^out_data[8*j +: 8];
    end
`endif

endmodule

// File: tb/tb_aes_state_unloader.sv
// Bench for aes_state_unloader: directed and random blocks against a byte-list model.
// Parity checks are active when AES_UNLOAD_PARITY_EN is defined.
module tb_aes_state_unloader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic               in_valid, in_ready;
    logic [15:0][7:0]   in_data;
    logic               out_valid, out_ready, out_last, busy;
    logic [7:0]         out_data;

    logic               in_valid4, in_ready4;
    logic [15:0][7:0]   in_data4;
    logic               out_valid4, out_ready4, out_last4, busy4;
    logic [31:0]        out_data4;

`ifdef AES_UNLOAD_PARITY_EN
    logic [0:0] par1;
    logic [3:0] par4;
`endif

    aes_state_unloader #(.N(16), .BEAT_BYTES(1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
`ifdef AES_UNLOAD_PARITY_EN
        .out_parity(par1),
`endif
        .busy(busy)
    );

    aes_state_unloader #(.N(16), .BEAT_BYTES(4)) dut4 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_data(out_data4), .out_last(out_last4),
`ifdef AES_UNLOAD_PARITY_EN
        .out_parity(par4),
`endif
        .busy(busy4)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0][7:0] rand_block();
        logic [15:0][7:0] b;
        for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
        return b;
    endfunction

    // Model: beat k of width bb is bytes k*bb..k*bb+bb-1, byte 0 in low lane.
    function automatic logic [31:0] beat_of(input logic [15:0][7:0] b,
                                            input int k, input int bb);
        logic [31:0] v = 0;
        for (int j = 0; j < bb; j++) v |= 32'(b[k*bb + j]) << (8*j);
        return v;
    endfunction

    function automatic logic [31:0] par_of(input logic [31:0] v, input int bb);
        logic [31:0] p = 0;
        for (int j = 0; j < bb; j++)
            p[j] = 1'(($countones(v[8*j +: 8])) % 2);
        return p;
    endfunction

    function automatic logic ready_for(input int mode, input int phase);
        case (mode)
            0:       return 1'b1;
            1:       return (phase % 4 == 0) || (phase % 4 == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic capture1(input logic [15:0][7:0] b);
        int g = 0;
        while (!in_ready && g < 100) begin tick(); g++; end
        if (!in_ready) check("cap_wait_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
        in_data  = 'x;
    endtask

    task automatic drain1(input logic [15:0][7:0] b, input int mode,
                          input int stop_at);
        int k = 0;
        int g = 0;
        logic [7:0] prev = 0;
        logic prev_last = 0;
        logic stalled = 0;
        while (k < stop_at && g < 300) begin
            out_ready = ready_for(mode, g);
            check("valid", 32'(out_valid), 1);
            check("busy", 32'(busy), 1);
            check("in_ready_send", 32'(in_ready), 0);
            check("data", 32'(out_data), beat_of(b, k, 1));
            check("last", 32'(out_last), 32'(k == 15));
            if (stalled) begin
                check("hold_data", 32'(out_data), 32'(prev));
                check("hold_last", 32'(out_last), 32'(prev_last));
            end
`ifdef AES_UNLOAD_PARITY_EN
            check("parity", 32'(par1), par_of(beat_of(b, k, 1), 1));
`endif
            prev      = out_data;
            prev_last = out_last;
            stalled   = !out_ready;
            if (out_ready) k++;
            tick();
            g++;
        end
        out_ready = 1'b0;
        if (k < stop_at) check("drain_timeout", 0, 1);
    endtask

    task automatic check_idle1(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 1);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_last"}, 32'(out_last), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic run4(input logic [15:0][7:0] b, input int mode);
        int k = 0;
        int g = 0;
        logic [31:0] prev = 0;
        logic stalled = 0;
        in_valid4 = 1'b1;
        in_data4  = b;
        tick();
        in_valid4 = 1'b0;
        in_data4  = 'x;
        while (k < 4 && g < 100) begin
            out_ready4 = ready_for(mode, g);
            check("b4_valid", 32'(out_valid4), 1);
            check("b4_data", out_data4, beat_of(b, k, 4));
            check("b4_last", 32'(out_last4), 32'(k == 3));
            if (stalled) check("b4_hold", out_data4, prev);
`ifdef AES_UNLOAD_PARITY_EN
            check("b4_parity", 32'(par4), par_of(beat_of(b, k, 4), 4));
`endif
            prev    = out_data4;
            stalled = !out_ready4;
            if (out_ready4) k++;
            tick();
            g++;
        end
        out_ready4 = 1'b0;
        if (k < 4) check("b4_timeout", 0, 1);
        check("b4_idle_ready", 32'(in_ready4), 1);
        check("b4_idle_valid", 32'(out_valid4), 0);
    endtask

    logic [15:0][7:0] kat, blk_a, blk_b, seq;
    logic [31:0] kat4 [4];

    initial begin
        kat = {8'h89, 8'h60, 8'h49, 8'h4b, 8'h90, 8'h49, 8'hfc, 8'hea,
               8'hbf, 8'h45, 8'h67, 8'h51, 8'hca, 8'hb7, 8'ha2, 8'h8e};
        kat4 = '{32'hcab7a28e, 32'hbf456751, 32'h9049fcea, 32'h8960494b};
        for (int i = 0; i < 16; i++) seq[i] = 8'(i);

        reset = 1'b1;
        in_valid = 1'b0; in_data = 'x; out_ready = 1'b0;
        in_valid4 = 1'b0; in_data4 = 'x; out_ready4 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_idle1("rst");
        check("rst_data", 32'(out_data), 0);
        check("rst4_data", out_data4, 0);
        check("rst4_ready", 32'(in_ready4), 1);
`ifdef AES_UNLOAD_PARITY_EN
        check("rst_parity", 32'(par1), 0);
`endif
        tick();
        check_idle1("idle_x");

        // Known block, always ready, then the 1,0,0,1 stall pattern.
        check("kat_byte0", 32'(kat[0]), 32'h8e);
        capture1(kat);
        drain1(kat, 0, 16);
        check_idle1("kat_done");
        capture1(kat);
        drain1(kat, 1, 16);
        check_idle1("kat_stall_done");
`ifdef AES_UNLOAD_PARITY_EN
        check("par_8e", par_of(32'h8e, 1), 0);
        check("par_a2", par_of(32'ha2, 1), 1);
`endif

        // in_valid held across two blocks: B waits for A's last beat.
        blk_a = rand_block();
        blk_b = rand_block();
        in_valid = 1'b1;
        in_data  = blk_a;
        tick();
        in_data = blk_b;
        drain1(blk_a, 0, 16);
        check("ab_idle_ready", 32'(in_ready), 1);
        check("ab_idle_valid", 32'(out_valid), 0);
        tick();
        in_valid = 1'b0;
        in_data  = 'x;
        drain1(blk_b, 2, 16);
        check_idle1("ab_done");

        // Reset mid-stream at beat 5.
        capture1(kat);
        drain1(kat, 0, 5);
        check("mid_beat5", 32'(out_data), 32'(kat[5]));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle1("mid_rst");
        check("mid_rst_data", 32'(out_data), 0);
        capture1(seq);
        drain1(seq, 0, 16);
        check_idle1("seq_done");

        // Random blocks with random backpressure.
        for (int r = 0; r < 6; r++) begin
            blk_a = rand_block();
            capture1(blk_a);
            drain1(blk_a, 2, 16);
            check_idle1("rnd_done");
        end

        // Four-byte beats.
        for (int k = 0; k < 4; k++)
            check("kat4_model", beat_of(kat, k, 4), kat4[k]);
        run4(kat, 0);
        run4(kat, 1);
        for (int r = 0; r < 4; r++) run4(rand_block(), 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
